// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage register with an optional 2-entry skid buffer.
// The payload is squashed to BUBBLE on flush or empty; the sideband keeps being captured.
module pipe_stage_elastic #(
    parameter int                 DATA_W = 32,
    parameter int                 SIDE_W = 32,
    parameter logic [DATA_W-1:0]  BUBBLE = '0,
    parameter int                 SKID   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SIDE_W-1:0] out_side,
    output logic [1:0]        occupancy,
    output logic [1:0]        dbg_state
);

    // Handshake: a beat moves on a rising edge when valid & ready are both high.
    // valid never waits on ready; once valid is raised, data/side stay stable until the beat fires.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] m_d;
    logic [SIDE_W-1:0] m_s;
    logic [DATA_W-1:0] s_d;
    logic [SIDE_W-1:0] s_s;
    logic              m_v;
    logic              s_v;
    logic              in_fire;
    logic              out_fire;

    assign m_v = (state != ST_EMPTY);
    assign s_v = (state == ST_FULL);

    // With the skid buffer, ready comes straight from state so out_ready never reaches in_ready.
    assign in_ready = (SKID != 0) ? !s_v : (out_ready || !m_v);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = m_v && out_ready;

    assign out_valid = m_v;
    assign out_data  = m_d;
    assign out_side  = m_s;
    assign occupancy = {1'b0, m_v} + {1'b0, s_v};
    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
            m_d   <= BUBBLE;
            m_s   <= '0;
            s_d   <= BUBBLE;
            s_s   <= '0;
        end else if (flush) begin
            // The incoming beat is swallowed, but its sideband is kept for the redirect target.
            state <= ST_EMPTY;
            m_d   <= BUBBLE;
            m_s   <= in_side;
            s_d   <= BUBBLE;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state <= ST_ONE;
                        m_d   <= in_data;
                        m_s   <= in_side;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        m_d <= in_data;
                        m_s <= in_side;
                    end else if (in_fire && (SKID != 0)) begin
                        state <= ST_FULL;
                        s_d   <= in_data;
                        s_s   <= in_side;
                    end else if (out_fire) begin
                        state <= ST_EMPTY;
                        m_d   <= BUBBLE;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state <= ST_ONE;
                        m_d   <= s_d;
                        m_s   <= s_s;
                        s_d   <= BUBBLE;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                    m_d   <= BUBBLE;
                    s_d   <= BUBBLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: one skid instance and one combinational-ready instance,
// both compared against a queue-based model of an elastic FIFO stage.
module tb_pipe_stage_elastic;

    localparam logic [31:0] BUB = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        flush;

    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] in_data1, in_side1, out_data1, out_side1;
    logic [1:0]  occupancy1, dbg_state1;

    logic        in_valid0, in_ready0, out_valid0, out_ready0;
    logic [31:0] in_data0, in_side0, out_data0, out_side0;
    logic [1:0]  occupancy0, dbg_state0;

    pipe_stage_elastic #(.DATA_W(32), .SIDE_W(32), .BUBBLE(BUB), .SKID(1)) u_skid (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_side(in_side1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_side(out_side1),
        .occupancy(occupancy1), .dbg_state(dbg_state1)
    );

    pipe_stage_elastic #(.DATA_W(32), .SIDE_W(32), .BUBBLE(BUB), .SKID(0)) u_comb (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_side(in_side0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_side(out_side0),
        .occupancy(occupancy0), .dbg_state(dbg_state0)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: each stage is a bounded FIFO of {data, side}
    logic [63:0] q1[$];
    logic [63:0] q0[$];
    logic [31:0] hold1, hold0;

    task automatic model_clear();
        q1.delete();
        q0.delete();
        hold1 = '0;
        hold0 = '0;
    endtask

    task automatic idle_inputs();
        flush = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; in_side1 = '0; out_ready1 = 1'b0;
        in_valid0 = 1'b0; in_data0 = '0; in_side0 = '0; out_ready0 = 1'b0;
    endtask

    // advance one clock: inputs are stable from the preceding negedge
    task automatic tick();
        bit f1, o1, f0, o0;
        f1 = in_valid1 && (q1.size() < 2);
        o1 = out_ready1 && (q1.size() != 0);
        f0 = in_valid0 && ((q0.size() == 0) || out_ready0);
        o0 = out_ready0 && (q0.size() != 0);
        @(posedge clock);
        if (!reset) begin
            model_clear();
        end else if (flush) begin
            q1.delete();
            q0.delete();
            hold1 = in_side1;
            hold0 = in_side0;
        end else begin
            if (o1) begin hold1 = q1[0][31:0]; void'(q1.pop_front()); end
            if (f1) q1.push_back({in_data1, in_side1});
            if (o0) begin hold0 = q0[0][31:0]; void'(q0.pop_front()); end
            if (f0) q0.push_back({in_data0, in_side0});
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({out_valid1, out_data1, out_side1, occupancy1, in_ready1} !== {1'b0, BUB, 32'h0, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_skid: got v=%b d=%h s=%h occ=%0d rdy=%b, want v=0 d=%h s=0 occ=0 rdy=1",
                     out_valid1, out_data1, out_side1, occupancy1, in_ready1, BUB);
        end
        n_tests++;
        if ({out_valid0, out_data0, out_side0, occupancy0, in_ready0} !== {1'b0, BUB, 32'h0, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_comb: got v=%b d=%h s=%h occ=%0d rdy=%b, want v=0 d=%h s=0 occ=0 rdy=1",
                     out_valid0, out_data0, out_side0, occupancy0, in_ready0, BUB);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_streaming();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        out_ready1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid1 = (i < 3);
            in_data1  = (i < 3) ? vals[i] : 32'h0;
            in_side1  = 32'h1000 + i;
            #1;
            n_tests++;
            if (in_ready1 !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready1);
            end
            if (i > 0) begin
                n_tests++;
                if ({out_valid1, out_data1, occupancy1} !== {1'b1, vals[i-1], 2'd1}) begin
                    n_fail++;
                    $display("FAIL stream_out[%0d]: got v=%b d=%h occ=%0d want v=1 d=%h occ=1",
                             i, out_valid1, out_data1, occupancy1, vals[i-1]);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_stall_full();
        in_valid1 = 1'b1; in_data1 = 32'h11; in_side1 = 32'h1011; out_ready1 = 1'b0;
        tick();
        in_data1 = 32'h22; in_side1 = 32'h1022;
        #1;
        n_tests++;
        if (in_ready1 !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_one_ready: got %b want 1", in_ready1);
        end
        tick();
        in_data1 = 32'h33; in_side1 = 32'h1033;
        #1;
        n_tests++;
        if ({out_data1, occupancy1, in_ready1} !== {32'h11, 2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_full: got d=%h occ=%0d rdy=%b want d=11 occ=2 rdy=0",
                     out_data1, occupancy1, in_ready1);
        end
        tick();
        out_ready1 = 1'b1;
        #1;
        n_tests++;
        if ({out_valid1, out_data1, out_side1, in_ready1} !== {1'b1, 32'h11, 32'h1011, 1'b0}) begin
            n_fail++;
            $display("FAIL drain_a: got v=%b d=%h s=%h rdy=%b want v=1 d=11 s=1011 rdy=0",
                     out_valid1, out_data1, out_side1, in_ready1);
        end
        tick();
        #1;
        n_tests++;
        if ({out_valid1, out_data1, out_side1, in_ready1} !== {1'b1, 32'h22, 32'h1022, 1'b1}) begin
            n_fail++;
            $display("FAIL drain_b: got v=%b d=%h s=%h rdy=%b want v=1 d=22 s=1022 rdy=1",
                     out_valid1, out_data1, out_side1, in_ready1);
        end
        tick();
        in_valid1 = 1'b0;
        #1;
        n_tests++;
        if ({out_valid1, out_data1, occupancy1} !== {1'b1, 32'h33, 2'd1}) begin
            n_fail++;
            $display("FAIL drain_c: got v=%b d=%h occ=%0d want v=1 d=33 occ=1", out_valid1, out_data1, occupancy1);
        end
        tick();
        #1;
        n_tests++;
        if ({out_valid1, out_data1, occupancy1} !== {1'b0, BUB, 2'd0}) begin
            n_fail++;
            $display("FAIL drain_empty: got v=%b d=%h occ=%0d want v=0 d=%h occ=0", out_valid1, out_data1, occupancy1, BUB);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        in_valid1 = 1'b1; in_data1 = 32'h44; in_side1 = 32'h2044; out_ready1 = 1'b0;
        tick();
        in_data1 = 32'h55; in_side1 = 32'h2055;
        tick();
        flush = 1'b1; in_data1 = 32'h66; in_side1 = 32'h0040_0010;
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if ({out_valid1, out_data1, out_side1, occupancy1, in_ready1} !== {1'b0, BUB, 32'h0040_0010, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_full: got v=%b d=%h s=%h occ=%0d rdy=%b want v=0 d=%h s=00400010 occ=0 rdy=1",
                     out_valid1, out_data1, out_side1, occupancy1, in_ready1, BUB);
        end
        tick();
    endtask

    task automatic test_drain();
        in_valid1 = 1'b1; in_data1 = 32'hABCD; in_side1 = 32'h1234; out_ready1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        #1;
        n_tests++;
        if ({out_valid1, out_data1} !== {1'b1, 32'hABCD}) begin
            n_fail++;
            $display("FAIL drain_beat: got v=%b d=%h want v=1 d=abcd", out_valid1, out_data1);
        end
        tick();
        #1;
        n_tests++;
        if ({out_valid1, out_data1, out_side1} !== {1'b0, BUB, 32'h1234}) begin
            n_fail++;
            $display("FAIL drain_side: got v=%b d=%h s=%h want v=0 d=%h s=1234", out_valid1, out_data1, out_side1, BUB);
        end
        idle_inputs();
    endtask

    task automatic test_comb_ready();
        in_valid0 = 1'b1; in_data0 = 32'h77; in_side0 = 32'h3077; out_ready0 = 1'b0;
        tick();
        in_data0 = 32'h88; in_side0 = 32'h3088;
        #1;
        n_tests++;
        if (in_ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL comb_stall_ready: got %b want 0", in_ready0);
        end
        out_ready0 = 1'b1;
        #1;
        n_tests++;
        if (in_ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL comb_ready_follow: got %b want 1", in_ready0);
        end
        tick();
        in_valid0 = 1'b0;
        #1;
        n_tests++;
        if ({out_valid0, out_data0, out_side0, occupancy0} !== {1'b1, 32'h88, 32'h3088, 2'd1}) begin
            n_fail++;
            $display("FAIL comb_pass: got v=%b d=%h s=%h occ=%0d want v=1 d=88 s=3088 occ=1",
                     out_valid0, out_data0, out_side0, occupancy0);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_async_reset();
        in_valid1 = 1'b1; in_data1 = 32'h99; in_side1 = 32'h4099; out_ready1 = 1'b0;
        tick();
        in_data1 = 32'hAA; in_side1 = 32'h40AA;
        tick();
        in_valid1 = 1'b0;
        #3 reset = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if ({out_valid1, out_data1, occupancy1, in_ready1} !== {1'b0, BUB, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b d=%h occ=%0d rdy=%b want v=0 d=%h occ=0 rdy=1",
                     out_valid1, out_data1, occupancy1, in_ready1, BUB);
        end
        @(negedge clock);
        reset = 1'b1;
        in_valid1 = 1'b1; in_data1 = 32'hBB; in_side1 = 32'h40BB; out_ready1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        #1;
        n_tests++;
        if ({out_valid1, out_data1, out_side1} !== {1'b1, 32'hBB, 32'h40BB}) begin
            n_fail++;
            $display("FAIL after_reset: got v=%b d=%h s=%h want v=1 d=bb s=40bb", out_valid1, out_data1, out_side1);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        logic [67:0] exp1, exp0, act1, act0;
        for (int c = 0; c < 600; c++) begin
            in_valid1  = ($urandom_range(0, 3) != 0);
            in_data1   = $urandom;
            in_side1   = $urandom;
            out_ready1 = ($urandom_range(0, 2) != 0);
            in_valid0  = ($urandom_range(0, 3) != 0);
            in_data0   = $urandom;
            in_side0   = $urandom;
            out_ready0 = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            #1;
            if (q1.size() != 0) exp1 = {1'b1, q1[0][63:32], q1[0][31:0], 2'(q1.size()), 1'(q1.size() < 2)};
            else                exp1 = {1'b0, BUB, hold1, 2'd0, 1'b1};
            if (q0.size() != 0) exp0 = {1'b1, q0[0][63:32], q0[0][31:0], 2'(q0.size()), out_ready0};
            else                exp0 = {1'b0, BUB, hold0, 2'd0, 1'b1};
            act1 = {out_valid1, out_data1, out_side1, occupancy1, in_ready1};
            act0 = {out_valid0, out_data0, out_side0, occupancy0, in_ready0};
            n_tests++;
            if (act1 !== exp1) begin
                n_fail++;
                $display("FAIL rand_skid[%0d]: got {v,d,s,occ,rdy}=%h want %h", c, act1, exp1);
            end
            n_tests++;
            if (act0 !== exp0) begin
                n_fail++;
                $display("FAIL rand_comb[%0d]: got {v,d,s,occ,rdy}=%h want %h", c, act0, exp0);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_clear();
        @(negedge clock);
        test_reset();
        test_streaming();
        test_stall_full();
        test_flush();
        test_drain();
        test_comb_ready();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Generic, parametrised pipeline stage register for the pipelined MIPS core. It replaces hard-wired stall/flush stage registers such as fetch/decode with a valid/ready elastic stage. The stage carries a payload field, which is cleared to a bubble value on flush, and a sideband field (for example PC+4), which keeps being captured on flush. An optional 2-entry skid buffer breaks the combinational ready path between stages.

Parameters:
DATA_W, 32, payload width (instruction word or control bundle)
SIDE_W, 32, sideband width (PC+4 or similar)
BUBBLE, 0, payload value held whenever the stage holds no valid beat (NOP encoding)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous squash of all held beats (branch taken / exception)
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat this cycle
in_data  input  DATA_W  upstream payload
in_side  input  SIDE_W  upstream sideband
out_valid  output  1  main entry holds a valid beat
out_ready  input  1  downstream accepts (deasserted = stall)
out_data  output  DATA_W  main entry payload
out_side  output  SIDE_W  main entry sideband
occupancy  output  2  number of valid entries (0..2)

Behaviour:
- Storage: main entry {m_v, m_d, m_s} drives the out_* ports. Skid entry {s_v, s_d, s_s} exists only when SKID=1.
- Fire conditions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (async, reset=0): m_v=0, s_v=0, m_d=s_d=BUBBLE, m_s=s_s=0. Resulting outputs: out_valid=0, out_data=BUBBLE, out_side=0, occupancy=0. in_ready=1 while reset is held and after release.
- Priority each edge: reset > flush > handshake updates.
- Flush (when reset is released): m_v=0, s_v=0, m_d=s_d=BUBBLE, m_s<=in_side. Any input beat in that cycle is consumed and dropped. Next cycle: out_valid=0, out_data=BUBBLE, occupancy=0.
- SKID=1: in_ready = !s_v, taken directly from a register with no path from out_ready.
- SKID=1 states: EMPTY (m_v=0), ONE (m_v=1, s_v=0), FULL (m_v=1, s_v=1).
  - EMPTY + in_fire -> ONE, main<=in.
  - ONE + in_fire & out_fire -> ONE, main<=in.
  - ONE + in_fire & !out_fire -> FULL, skid<=in, main holds.
  - ONE + !in_fire & out_fire -> EMPTY, m_d<=BUBBLE, m_s holds.
  - ONE + no fire -> hold (stall).
  - FULL + out_fire -> ONE, main<=skid, s_v=0, s_d<=BUBBLE. No in_fire is possible in FULL.
  - FULL + !out_fire -> hold.
- SKID=0: in_ready = out_ready | !m_v (combinational). in_fire loads main. Otherwise out_fire empties main (m_d<=BUBBLE). Otherwise hold.
- Latency: a beat accepted on an edge appears on out_* in the next cycle when the stage is EMPTY, or when in ONE with out_fire. Throughput is 1 beat/cycle with continuous out_ready.
- Ordering: beats leave in acceptance order. No beat is duplicated or lost, except beats squashed by flush.
- Payload is never X: whenever m_v=0, out_data=BUBBLE.
- occupancy = m_v + s_v. It is never 2 when SKID=0.
- Simultaneous flush and stall: flush wins; the stage empties regardless of out_ready.
- Reset mid-transfer drops all beats; no partial state survives.

Test Plan:
- Streaming, SKID=1, out_ready=1: in_data=0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each; in_ready stays 1; occupancy=1.
- Stall to FULL: with 0x11 held, drop out_ready and offer 0x22, then 0x33 -> 0x22 goes to skid, occupancy=2, in_ready=0, 0x33 is held upstream. Raise out_ready -> outputs 0x11, 0x22, 0x33 in order, with no loss.
- Flush in FULL with out_ready=0 and in_side=0x00400010 -> next cycle out_valid=0, out_data=BUBBLE, out_side=0x00400010, occupancy=0, in_ready=1.
- Drain: single beat 0xABCD accepted, then in_valid=0 with out_ready=1 -> next cycle out_valid=0, out_data=BUBBLE, out_side equals the last beat's side.
- SKID=0, out_ready=0 with main valid -> in_ready=0 in the same cycle. Raise out_ready with in_valid=1 -> pass-through with no bubble.
- Async reset asserted mid-FULL, between clock edges -> outputs immediately show out_valid=0, out_data=BUBBLE, occupancy=0. After release, the first accepted beat appears one cycle later.
